byte_bridge: RTL and testbench

BYTE_BRIDGE -- requirements
Module: byte_bridge

---
 rtl/machina_pkg.sv | 20 ++
 rtl/byte_unpack.sv | 74 +++++++
 rtl/byte_bridge.sv | 127 ++++++++++++
 tb/tb_byte_bridge.sv | 325 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/machina_pkg.sv
// Shared constants and FSM encodings for the byte bridge and its byte unpacker.
package machina_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic {
    COLLECT = 1'b0,
    ISSUE   = 1'b1
  } in_state_t;

  typedef enum logic {
    IDLE = 1'b0,
    EMIT = 1'b1
  } out_state_t;

  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/byte_unpack.sv
// Output side: takes one RESW-bit result and emits it as a little-endian byte stream.
module byte_unpack
  import machina_pkg::*;
#(
  parameter int RESW = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              res_stb,
  input  logic [RESW-1:0]   res_dat,
  output logic              res_rdy,
  output logic              tx_stb,
  output logic [BYTE_W-1:0] tx_dat,
  input  logic              tx_rdy
);

  localparam int NB = RESW / BYTE_W;
  localparam int CW = cnt_w(NB);
  localparam logic [CW-1:0] LAST = CW'(NB - 1);

  out_state_t        r_state;
  out_state_t        w_state_nxt;
  logic [RESW-1:0]   r_sh;
  logic [CW-1:0]     r_idx;
  logic              w_load;
  logic              w_shift;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= IDLE;
    else      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    res_rdy     = 1'b0;
    tx_stb      = 1'b0;
    w_load      = 1'b0;
    w_shift     = 1'b0;
    case (r_state)
      IDLE: begin
        res_rdy = 1'b1;
        if (res_stb) begin
          w_load      = 1'b1;
          w_state_nxt = EMIT;
        end
      end
      EMIT: begin
        tx_stb = 1'b1;
        if (tx_rdy) begin
          w_shift = 1'b1;
          if (r_idx == LAST) w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // The current byte always sits in the low lane; it only moves on a tx transfer.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sh  <= '0;
      r_idx <= '0;
    end else if (w_load) begin
      r_sh  <= res_dat;
      r_idx <= '0;
    end else if (w_shift) begin
      r_sh  <= r_sh >> BYTE_W;
      r_idx <= (r_idx == LAST) ? '0 : r_idx + CW'(1);
    end
  end

  assign tx_dat = r_sh[BYTE_W-1:0];

endmodule

// File: rtl/byte_bridge.sv
// Byte stream <-> operand/result bridge; the inter-byte gap timeout is built only
// when BYTE_BRIDGE_TIMEOUT_EN is defined.
module byte_bridge
  import machina_pkg::*;
#(
  parameter int ARGW    = 8,
  parameter int ARGC    = 2,
  parameter int RESW    = 16,
  parameter int TIMEOUT = 12000
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx_stb,
  input  logic [BYTE_W-1:0]    rx_dat,
  output logic                 rx_rdy,
  input  logic                 rx_err,
  output logic                 arg_stb,
  output logic [ARGC*ARGW-1:0] arg_dat,
  input  logic                 arg_rdy,
  input  logic                 res_stb,
  input  logic [RESW-1:0]      res_dat,
  output logic                 res_rdy,
  output logic                 tx_stb,
  output logic [BYTE_W-1:0]    tx_dat,
  input  logic                 tx_rdy,
  output logic                 drp
);

  localparam int NBYTES = ARGC * ARGW / BYTE_W;
  localparam int CNT_W  = cnt_w(NBYTES);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(NBYTES - 1);

  in_state_t              r_state;
  in_state_t              w_state_nxt;
  logic [CNT_W-1:0]       r_cnt;
  logic [ARGC*ARGW-1:0]   r_arg;
  logic                   r_drp;
  logic                   w_take;
  logic                   w_abort;
  logic                   w_tmo;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= COLLECT;
    else      r_state <= w_state_nxt;
  end

  // A framing error on a partial frame wins over any byte offered in the same cycle.
  always_comb begin
    w_state_nxt = r_state;
    rx_rdy      = 1'b0;
    arg_stb     = 1'b0;
    w_take      = 1'b0;
    w_abort     = 1'b0;
    case (r_state)
      COLLECT: begin
        rx_rdy = 1'b1;
        if (rx_err && (r_cnt != '0)) begin
          w_abort = 1'b1;
        end else if (rx_stb) begin
          w_take = 1'b1;
          if (r_cnt == LAST) w_state_nxt = ISSUE;
        end
      end
      ISSUE: begin
        arg_stb = 1'b1;
        if (arg_rdy) w_state_nxt = COLLECT;
      end
      default: w_state_nxt = COLLECT;
    endcase
  end

`ifdef BYTE_BRIDGE_TIMEOUT_EN
  localparam int GAP_W = cnt_w(TIMEOUT);

  logic [GAP_W-1:0] r_gap;

  // Gap runs only while a frame is partially collected; the TIMEOUT-th idle cycle drops it.
  assign w_tmo = (r_cnt != '0) && !w_take && !w_abort && (r_gap == GAP_W'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_gap <= '0;
    end else if (w_take || w_abort || w_tmo || (r_cnt == '0)) begin
      r_gap <= '0;
    end else begin
      r_gap <= r_gap + GAP_W'(1);
    end
  end
`else
  assign w_tmo = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt <= '0;
      r_arg <= '0;
      r_drp <= 1'b0;
    end else begin
      r_drp <= w_abort | w_tmo;
      if (w_abort || w_tmo) begin
        r_cnt <= '0;
      end else if (w_take) begin
        r_cnt <= (r_cnt == LAST) ? '0 : r_cnt + CNT_W'(1);
        for (int k = 0; k < NBYTES; k++) begin
          if (r_cnt == CNT_W'(k)) r_arg[k*BYTE_W +: BYTE_W] <= rx_dat;
        end
      end
    end
  end

  assign arg_dat = r_arg;
  assign drp     = r_drp;

  byte_unpack #(
    .RESW(RESW)
  ) u_unpack (
    .clk     (clk),
    .rst     (rst),
    .res_stb (res_stb),
    .res_dat (res_dat),
    .res_rdy (res_rdy),
    .tx_stb  (tx_stb),
    .tx_dat  (tx_dat),
    .tx_rdy  (tx_rdy)
  );

endmodule

// File: tb/tb_byte_bridge.sv
// Directed bench for byte_bridge with a queue-level reference model of both stream sides.
module tb_byte_bridge;

  localparam int ARGW = 8;
  localparam int ARGC = 2;
  localparam int RESW = 16;
  localparam int TMO  = 20;
  localparam int NB   = ARGC * ARGW / 8;
  localparam int RB   = RESW / 8;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 rx_stb = 1'b0;
  logic [7:0]           rx_dat = '0;
  logic                 rx_rdy;
  logic                 rx_err = 1'b0;
  logic                 arg_stb;
  logic [ARGC*ARGW-1:0] arg_dat;
  logic                 arg_rdy = 1'b1;
  logic                 res_stb = 1'b0;
  logic [RESW-1:0]      res_dat = '0;
  logic                 res_rdy;
  logic                 tx_stb;
  logic [7:0]           tx_dat;
  logic                 tx_rdy = 1'b1;
  logic                 drp;

  int n_vec = 0;
  int n_err = 0;
  int n_drp = 0;
  int n0;
  logic [7:0] seen[$];

  // Reference model state
  logic [7:0]           m_part[$];
  logic [7:0]           m_txq[$];
  logic                 m_pend;
  logic [ARGC*ARGW-1:0] m_arg;
  logic                 m_drp;
  int                   m_gap;

  byte_bridge #(
    .ARGW(ARGW), .ARGC(ARGC), .RESW(RESW), .TIMEOUT(TMO)
  ) dut (
    .clk(clk), .rst(rst),
    .rx_stb(rx_stb), .rx_dat(rx_dat), .rx_rdy(rx_rdy), .rx_err(rx_err),
    .arg_stb(arg_stb), .arg_dat(arg_dat), .arg_rdy(arg_rdy),
    .res_stb(res_stb), .res_dat(res_dat), .res_rdy(res_rdy),
    .tx_stb(tx_stb), .tx_dat(tx_dat), .tx_rdy(tx_rdy),
    .drp(drp)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic bound_fail(input string nm);
    n_vec++;
    n_err++;
    $display("FAIL %s: handshake did not happen within bound (t=%0t)", nm, $time);
  endtask

  // Frame model: bytes gather little-endian; a full frame is presented until taken.
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_part.delete();
      m_txq.delete();
      m_pend = 1'b0;
      m_arg  = '0;
      m_drp  = 1'b0;
      m_gap  = 0;
    end else begin
      m_drp = 1'b0;
      if (m_pend) begin
        if (arg_rdy) m_pend = 1'b0;
      end else if (rx_err && m_part.size() != 0) begin
        m_part.delete();
        m_drp = 1'b1;
        m_gap = 0;
      end else if (rx_stb) begin
        m_part.push_back(rx_dat);
        m_gap = 0;
        if (m_part.size() == NB) begin
          for (int k = 0; k < NB; k++) m_arg[8*k +: 8] = m_part[k];
          m_pend = 1'b1;
          m_part.delete();
        end
      end
`ifdef BYTE_BRIDGE_TIMEOUT_EN
      else if (m_part.size() != 0) begin
        m_gap++;
        if (m_gap == TMO) begin
          m_part.delete();
          m_drp = 1'b1;
          m_gap = 0;
        end
      end
`endif
      if (m_txq.size() != 0) begin
        if (tx_rdy) void'(m_txq.pop_front());
      end else if (res_stb) begin
        for (int k = 0; k < RB; k++) m_txq.push_back(res_dat[8*k +: 8]);
      end
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      chk("rx_rdy", rx_rdy, !m_pend);
      chk("arg_stb", arg_stb, m_pend);
      if (m_pend) chk("arg_dat", arg_dat, m_arg);
      chk("drp", drp, m_drp);
      chk("res_rdy", res_rdy, m_txq.size() == 0);
      chk("tx_stb", tx_stb, m_txq.size() != 0);
      if (m_txq.size() != 0) chk("tx_dat", tx_dat, m_txq[0]);
      if (tx_stb && tx_rdy) seen.push_back(tx_dat);
      if (drp) n_drp++;
    end
  end

  task automatic send_byte(input logic [7:0] b);
    bit ok = 1'b0;
    rx_stb = 1'b1;
    rx_dat = b;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge clk);
      if (rx_rdy) ok = 1'b1;
    end
    if (!ok) bound_fail("rx_accept");
    @(posedge clk);
    #1 rx_stb = 1'b0;
  endtask

  task automatic send_res(input logic [RESW-1:0] r);
    bit ok = 1'b0;
    res_stb = 1'b1;
    res_dat = r;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge clk);
      if (res_rdy) ok = 1'b1;
    end
    if (!ok) bound_fail("res_accept");
    @(posedge clk);
    #1 res_stb = 1'b0;
  endtask

  task automatic pulse_err(input logic with_stb, input logic [7:0] b);
    rx_err = 1'b1;
    rx_stb = with_stb;
    rx_dat = b;
    @(posedge clk);
    #1;
    rx_err = 1'b0;
    rx_stb = 1'b0;
  endtask

  task automatic expect_frame(input string nm, input logic [15:0] exp);
    bit got = 1'b0;
    for (int i = 0; i < 100 && !got; i++) begin
      @(negedge clk);
      if (arg_stb && arg_rdy) begin
        got = 1'b1;
        chk(nm, arg_dat, exp);
      end
    end
    if (!got) bound_fail(nm);
    @(posedge clk);
    #1;
  endtask

  task automatic reset_lits(input string tag);
    chk({tag, "_rx_rdy"}, rx_rdy, 1'b1);
    chk({tag, "_arg_stb"}, arg_stb, 1'b0);
    chk({tag, "_arg_dat"}, arg_dat, 16'h0000);
    chk({tag, "_res_rdy"}, res_rdy, 1'b1);
    chk({tag, "_tx_stb"}, tx_stb, 1'b0);
    chk({tag, "_tx_dat"}, tx_dat, 8'h00);
    chk({tag, "_drp"}, drp, 1'b0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    #2 rst = 1'b0;
    #1 reset_lits("por");
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1;

    // two bytes form one operand vector, visible the cycle after the last byte
    send_byte(8'h03);
    send_byte(8'h05);
    chk("lat_arg_stb", arg_stb, 1'b1);
    chk("lat_arg_dat", arg_dat, 16'h0503);
    expect_frame("frame_0503", 16'h0503);

    // compute block stalls: vector holds, no byte taken
    arg_rdy = 1'b0;
    send_byte(8'h0A);
    send_byte(8'h0B);
    rx_stb = 1'b1;
    rx_dat = 8'hFF;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("stall_arg_stb", arg_stb, 1'b1);
      chk("stall_arg_dat", arg_dat, 16'h0B0A);
      chk("stall_rx_rdy", rx_rdy, 1'b0);
    end
    @(posedge clk);
    #1;
    rx_stb  = 1'b0;
    arg_rdy = 1'b1;
    expect_frame("stall_release", 16'h0B0A);
    send_byte(8'h21);
    send_byte(8'h43);
    expect_frame("after_stall", 16'h4321);

    // result emitted with a stuttering tx_rdy while a new frame is collected
    seen.delete();
    tx_rdy = 1'b0;
    fork
      begin
        send_res(16'hBEEF);
        for (int i = 0; i < 12; i++) begin
          @(posedge clk);
          #1 tx_rdy = ~tx_rdy;
        end
        tx_rdy = 1'b1;
      end
      begin
        send_byte(8'h55);
        send_byte(8'h66);
        expect_frame("overlap_frame", 16'h6655);
      end
    join
    repeat (2) @(posedge clk);
    #1;
    chk("tx_count", seen.size(), 2);
    chk("tx_byte0", seen[0], 8'hEF);
    chk("tx_byte1", seen[1], 8'hBE);
    chk("tx_done_res_rdy", res_rdy, 1'b1);

    // framing error mid-frame drops the partial bytes
    n0 = n_drp;
    send_byte(8'h11);
    pulse_err(1'b0, 8'h00);
    send_byte(8'h22);
    send_byte(8'h33);
    expect_frame("err_drop", 16'h3322);
    chk("err_drop_drp", n_drp - n0, 1);

    // error with a byte in the same cycle: the byte is ignored
    n0 = n_drp;
    send_byte(8'h44);
    pulse_err(1'b1, 8'h99);
    send_byte(8'h77);
    send_byte(8'h88);
    expect_frame("err_with_stb", 16'h8877);
    chk("err_with_stb_drp", n_drp - n0, 1);

    // error with nothing collected, and error while the vector waits
    n0 = n_drp;
    pulse_err(1'b0, 8'h00);
    arg_rdy = 1'b0;
    send_byte(8'h5A);
    send_byte(8'hA5);
    pulse_err(1'b0, 8'h00);
    arg_rdy = 1'b1;
    expect_frame("err_idle_issue", 16'hA55A);
    chk("err_idle_issue_drp", n_drp - n0, 0);

    // long inter-byte gap
    n0 = n_drp;
    send_byte(8'h11);
`ifdef BYTE_BRIDGE_TIMEOUT_EN
    repeat (TMO) @(posedge clk);
    #1;
    send_byte(8'h22);
    send_byte(8'h33);
    expect_frame("gap_timeout", 16'h3322);
    chk("gap_timeout_drp", n_drp - n0, 1);
`else
    repeat (2 * TMO) @(posedge clk);
    #1;
    send_byte(8'h22);
    expect_frame("gap_kept", 16'h2211);
    chk("gap_kept_drp", n_drp - n0, 0);
`endif

    // reset mid-frame and mid-emit
    n0 = n_drp;
    send_byte(8'h01);
    tx_rdy = 1'b0;
    send_res(16'h1234);
    @(posedge clk);
    #3 rst = 1'b0;
    #1 reset_lits("async");
    repeat (2) @(posedge clk);
    #1;
    rst    = 1'b1;
    tx_rdy = 1'b1;
    send_byte(8'h07);
    send_byte(8'h09);
    expect_frame("post_reset", 16'h0907);
    chk("post_reset_drp", n_drp - n0, 0);
    repeat (3) @(posedge clk);
    #1;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
